// File: rtl/clock_pkg.sv
// Shared clock-datapath definitions: 12-hour count geometry, BCD digit width,
// setter FSM states and the modulo-12 increment used by the hour registers.
package clock_pkg;

  localparam int CNT12_W   = 4;
  localparam int CNT12_MAX = 11;
  localparam int BCD_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } set_state_t;

  // 0 encodes 12 o'clock, so 11 wraps to 0.
  function automatic logic [CNT12_W-1:0] cnt12_inc(input logic [CNT12_W-1:0] cnt);
    return (cnt == CNT12_W'(CNT12_MAX)) ? '0 : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/hour12_bcd_loader_if.sv
// Set-request handshake between a time-setting source and hour12_bcd_loader.
// SET_AMPM exists only when HOUR12_AMPM_EN is defined.
interface hour12_bcd_loader_if;
  import clock_pkg::*;

  logic             SET_VALID;
  logic             SET_READY;
  logic             SET_HOUR10;
  logic [BCD_W-1:0] SET_HOUR1;
`ifdef HOUR12_AMPM_EN
  logic             SET_AMPM;
`endif

`ifdef HOUR12_AMPM_EN
  modport master (output SET_VALID, SET_HOUR10, SET_HOUR1, SET_AMPM, input SET_READY);
  modport slave  (input SET_VALID, SET_HOUR10, SET_HOUR1, SET_AMPM, output SET_READY);
`else
  modport master (output SET_VALID, SET_HOUR10, SET_HOUR1, input SET_READY);
  modport slave  (input SET_VALID, SET_HOUR10, SET_HOUR1, output SET_READY);
`endif

endinterface

// File: rtl/hour12_bcd_encoder.sv
// Combinational BCD hour (1..12) to 12-hour count encoder with legality flag.
module hour12_bcd_encoder
  import clock_pkg::*;
(
  input  logic               hour10,
  input  logic [BCD_W-1:0]   hour1,
  output logic [CNT12_W-1:0] cnt,
  output logic               legal
);

  always_comb begin
    // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
    cnt   = '0;
    legal = 1'b0;
    if (!hour10) begin
      if (hour1 >= BCD_W'(1) && hour1 <= BCD_W'(9)) begin
        legal = 1'b1;
        cnt   = hour1;
      end
    end else begin
      case (hour1)
        BCD_W'(0): begin legal = 1'b1; cnt = CNT12_W'(10); end
        BCD_W'(1): begin legal = 1'b1; cnt = CNT12_W'(11); end
        BCD_W'(2): begin legal = 1'b1; cnt = '0;           end
        default:   begin legal = 1'b0; cnt = '0;           end
      endcase
    end
  end

endmodule

// File: rtl/hour12_bcd_loader.sv
// Hour-keeping register with BCD time-set: validates and loads a BCD hour, advances on
// TICK_HOUR and flags the 11->12 rollover. Optional meridiem flag: HOUR12_AMPM_EN.
module hour12_bcd_loader
  import clock_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 TICK_HOUR,
  hour12_bcd_loader_if.slave   set_if,
  output logic [CNT12_W-1:0]   CNT12,
  output logic                 CARRY,
  output logic                 SET_ERR
`ifdef HOUR12_AMPM_EN
  ,
  output logic                 AMPM
`endif
);

  set_state_t         state;
  logic               set_ready;
  logic               hold_h10;
  logic [BCD_W-1:0]   hold_h1;
`ifdef HOUR12_AMPM_EN
  logic               hold_ampm;
`endif
  logic [CNT12_W-1:0] enc_cnt;
  logic               enc_legal;

  assign set_if.SET_READY = set_ready;

  hour12_bcd_encoder u_encoder (
    .hour10 (hold_h10),
    .hour1  (hold_h1),
    .cnt    (enc_cnt),
    .legal  (enc_legal)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      set_ready <= 1'b1;
      CNT12     <= '0;
      CARRY     <= 1'b0;
      SET_ERR   <= 1'b0;
      // NOTE: the holding registers are reset too; they are a few flops, not a memory.
      hold_h10  <= 1'b0;
      hold_h1   <= '0;
`ifdef HOUR12_AMPM_EN
      hold_ampm <= 1'b0;
      AMPM      <= 1'b0;
`endif
    end else begin
      CARRY   <= 1'b0;
      SET_ERR <= 1'b0;

      // A tick landing on the COMMIT edge is dropped: the load wins.
      if (TICK_HOUR && state != COMMIT) begin
        CNT12 <= cnt12_inc(CNT12);
        if (CNT12 == CNT12_W'(CNT12_MAX)) begin
          CARRY <= 1'b1;
`ifdef HOUR12_AMPM_EN
          AMPM  <= ~AMPM;
`endif
        end
      end

      case (state)
        IDLE: begin
          if (set_if.SET_VALID && set_ready) begin
            hold_h10  <= set_if.SET_HOUR10;
            hold_h1   <= set_if.SET_HOUR1;
`ifdef HOUR12_AMPM_EN
            hold_ampm <= set_if.SET_AMPM;
`endif
            set_ready <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (enc_legal) begin
            state <= COMMIT;
          end else begin
            SET_ERR   <= 1'b1;
            set_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        COMMIT: begin
          CNT12     <= enc_cnt;
`ifdef HOUR12_AMPM_EN
          AMPM      <= hold_ampm;
`endif
          set_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          set_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
